// File: rtl/sram_march_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
package sram_march_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    E0,
    E1,
    E2,
    E3,
    E4,
    E5
  } elem_e;

  localparam int unsigned NumElems = 6;

  // Ops inside an element always run read-then-write; a 1-op element is either
  // a pure write (E0) or a pure read (E5), selected by has_read.
  typedef struct packed {
    logic       down;
    logic [1:0] num_ops;
    logic       has_read;
    logic       rd_val;
    logic       wr_val;
  } elem_cfg_t;

  localparam elem_cfg_t [NumElems-1:0] ElemTable = {
    elem_cfg_t'{down: 1'b0, num_ops: 2'd1, has_read: 1'b1, rd_val: 1'b0, wr_val: 1'b0}, // E5 r0
    elem_cfg_t'{down: 1'b1, num_ops: 2'd2, has_read: 1'b1, rd_val: 1'b1, wr_val: 1'b0}, // E4 r1,w0
    elem_cfg_t'{down: 1'b1, num_ops: 2'd2, has_read: 1'b1, rd_val: 1'b0, wr_val: 1'b1}, // E3 r0,w1
    elem_cfg_t'{down: 1'b0, num_ops: 2'd2, has_read: 1'b1, rd_val: 1'b1, wr_val: 1'b0}, // E2 r1,w0
    elem_cfg_t'{down: 1'b0, num_ops: 2'd2, has_read: 1'b1, rd_val: 1'b0, wr_val: 1'b1}, // E1 r0,w1
    elem_cfg_t'{down: 1'b0, num_ops: 2'd1, has_read: 1'b0, rd_val: 1'b0, wr_val: 1'b0}  // E0 w0
  };

endpackage

// File: rtl/sram_march_bist.sv
// March C- BIST engine driving one latency-1 single-port SRAM, one op per cycle.
//   state   | meaning
//   StIdle  | waiting for start_i, results held
//   StRun   | issuing march ops, comparing reads one cycle later
//   StDrain | last read in flight, final compare
//   StDone  | one-cycle done_o pulse
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic [DataWidth-1:0] rdata_i
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] OneAddr  = AddrWidth'(1);

  state_e                 state_q, state_d;
  elem_e                  elem_q, elem_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   phase_q, phase_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   exp_q, exp_d;
  logic [AddrWidth-1:0]   rd_addr_q, rd_addr_d;
  logic                   pass_q, pass_d;
  logic [AddrWidth-1:0]   fail_addr_q, fail_addr_d;

  elem_cfg_t cfg;
  elem_e     elem_next;
  logic      next_down;
  logic      op_read, last_op, last_addr, mismatch;

  always_comb begin
    cfg       = ElemTable[elem_q];
    elem_next = elem_e'(elem_q + 3'd1);
    next_down = ElemTable[elem_next].down;
    op_read   = cfg.has_read & ~phase_q;
    last_op   = ({1'b0, phase_q} == (cfg.num_ops - 2'd1));
    last_addr = cfg.down ? (addr_q == '0) : (addr_q == LastAddr);
    mismatch  = rd_pend_q & (rdata_i != {DataWidth{exp_q}});
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    rd_pend_d   = 1'b0;
    exp_d       = exp_q;
    rd_addr_d   = rd_addr_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          elem_d      = E0;
          addr_d      = '0;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      StRun: begin
        rd_pend_d = op_read;
        exp_d     = cfg.rd_val;
        rd_addr_d = addr_q;
        if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = cfg.down ? (addr_q - OneAddr) : (addr_q + OneAddr);
          end else if (elem_q == E5) begin
            state_d = StDrain;
            addr_d  = '0;
          end else begin
            elem_d = elem_next;
            addr_d = next_down ? LastAddr : '0;
          end
        end
      end
      StDrain: begin
        state_d = StDone;
        pass_d  = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // First miscompare aborts the sweep; any further in-flight read is dropped.
    if (mismatch) begin
      state_d     = StDone;
      pass_d      = 1'b0;
      fail_addr_d = rd_addr_q;
      rd_pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      elem_q      <= E0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      exp_q       <= 1'b0;
      rd_addr_q   <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      rd_pend_q   <= rd_pend_d;
      exp_q       <= exp_d;
      rd_addr_q   <= rd_addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  always_comb begin
    req_o       = (state_q == StRun);
    we_o        = req_o & ~op_read;
    addr_o      = req_o ? addr_q : '0;
    wdata_o     = {DataWidth{we_o & cfg.wr_val}};
    be_o        = {BeWidth{req_o}};
    busy_o      = (state_q == StRun) || (state_q == StDrain);
    done_o      = (state_q == StDone);
    pass_o      = pass_q;
    fail_addr_o = fail_addr_q;
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two configurations against fault-injecting SRAM models
// and an array-walking March C- reference.
module tb_sram_march_bist;
  localparam int N0 = 64, W0 = 64, N1 = 48, W1 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_req = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic start0, start1;
  assign start0 = start_req & ~sel;
  assign start1 = start_req & sel;

  logic        busy0, done0, pass0, req0, we0;
  logic [5:0]  fa0, addr0;
  logic [63:0] wdata0, rdata0;
  logic [7:0]  be0;
  logic        busy1, done1, pass1, req1, we1;
  logic [5:0]  fa1, addr1;
  logic [31:0] wdata1, rdata1;
  logic [3:0]  be1;

  sram_march_bist #(.NumWords(N0), .DataWidth(W0), .ByteWidth(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .pass_o(pass0), .fail_addr_o(fa0), .req_o(req0), .we_o(we0), .addr_o(addr0),
    .wdata_o(wdata0), .be_o(be0), .rdata_i(rdata0));

  sram_march_bist #(.NumWords(N1), .DataWidth(W1), .ByteWidth(8)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .fail_addr_o(fa1), .req_o(req1), .we_o(we1), .addr_o(addr1),
    .wdata_o(wdata1), .be_o(be1), .rdata_i(rdata1));

  // Fault configuration: 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 coupling
  int          fault_kind = 0;
  int          f_addr = 0;
  logic [63:0] f_mask = '0;
  int          c_agg = 0, c_vic = 1;

  function automatic logic [63:0] apply_stuck(input int a, input logic [63:0] v);
    if (fault_kind == 1 && a == f_addr) return v | f_mask;
    if (fault_kind == 2 && a == f_addr) return v & ~f_mask;
    return v;
  endfunction

  logic [63:0] mem0 [N0];
  logic [31:0] mem1 [N1];

  always @(posedge clk) begin
    if (req0) begin
      if (we0) begin
        mem0[addr0] <= wdata0;
        if (fault_kind == 3 && wdata0 == '1 && int'(addr0) == c_agg) mem0[c_vic] <= ~mem0[c_vic];
      end else begin
        rdata0 <= apply_stuck(int'(addr0), mem0[addr0]);
      end
    end
  end

  always @(posedge clk) begin
    if (req1) begin
      if (we1) begin
        mem1[addr1] <= wdata1;
        if (fault_kind == 3 && wdata1 == '1 && int'(addr1) == c_agg) mem1[c_vic] <= ~mem1[c_vic];
      end else begin
        rdata1 <= 32'(apply_stuck(int'(addr1), {32'b0, mem1[addr1]}));
      end
    end
  end

  logic        c_req, c_we, c_busy, c_done, c_pass;
  logic [5:0]  c_addr, c_fa;
  logic [63:0] c_wdata;
  logic [7:0]  c_be;
  always_comb begin
    if (!sel) begin
      c_req = req0; c_we = we0; c_busy = busy0; c_done = done0; c_pass = pass0;
      c_addr = addr0; c_fa = fa0; c_wdata = wdata0; c_be = be0;
    end else begin
      c_req = req1; c_we = we1; c_busy = busy1; c_done = done1; c_pass = pass1;
      c_addr = addr1; c_fa = fa1; c_wdata = {32'b0, wdata1}; c_be = {4'b0, be1};
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk March C- over a plain array carrying the same fault.
  int q_addr[$];
  bit q_we[$];
  bit q_wv[$];
  int fail_idx, fail_addr;

  task automatic build_model(input int n, input int w);
    logic [63:0] m[];
    logic [63:0] ones, v;
    int idx, a;
    bit down, rdv, wrv;
    ones = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    m = new[n];
    foreach (m[i]) m[i] = '0;
    q_addr.delete(); q_we.delete(); q_wv.delete();
    fail_idx = -1; fail_addr = 0; idx = 0;
    for (int e = 0; e < 6; e++) begin
      down = (e == 3 || e == 4);
      rdv  = (e == 2 || e == 4);
      wrv  = (e == 1 || e == 3);
      for (int i = 0; i < n; i++) begin
        a = down ? n - 1 - i : i;
        if (e != 0) begin
          q_addr.push_back(a); q_we.push_back(1'b0); q_wv.push_back(1'b0);
          v = apply_stuck(a, m[a]) & ones;
          if (fail_idx < 0 && v != (rdv ? ones : 64'b0)) begin
            fail_idx = idx; fail_addr = a;
          end
          idx++;
        end
        if (e != 5) begin
          q_addr.push_back(a); q_we.push_back(1'b1); q_wv.push_back(wrv);
          m[a] = wrv ? ones : 64'b0;
          if (fault_kind == 3 && wrv && a == c_agg) m[c_vic] = ~m[c_vic] & ones;
          idx++;
        end
      end
    end
  endtask

  task automatic run_test(input bit s, input int restart_at, input int reset_at);
    int n, w, exp_req, exp_done, nreq, maxaddr;
    bit got_done, stream_ok, ok;
    logic [63:0] ones, exp_wd;
    n = s ? N1 : N0;
    w = s ? W1 : W0;
    ones = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    sel = s;
    build_model(n, w);
    exp_req  = (fail_idx >= 0) ? ((fail_idx + 2 < 10 * n) ? fail_idx + 2 : 10 * n) : 10 * n;
    exp_done = (fail_idx >= 0) ? fail_idx + 3 : 10 * n + 2;
    @(negedge clk);
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    got_done = 1'b0; nreq = 0; stream_ok = 1'b1; maxaddr = 0;
    for (int k = 1; k <= 10 * n + 20; k++) begin
      @(negedge clk);
      start_req = (k == restart_at);
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_req", 64'(c_req), 64'd0);
        check("rst_busy", 64'(c_busy), 64'd0);
        check("rst_pass", 64'(c_pass), 64'd0);
        check("rst_bus", 64'(c_we) | 64'(c_addr) | c_wdata, 64'd0);
        repeat (3) begin
          @(negedge clk);
          check("rst_no_done", 64'(c_done), 64'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (k == 1) begin
        check("pass_cleared", 64'(c_pass), 64'd0);
        check("fail_addr_cleared", 64'(c_fa), 64'd0);
      end
      check("req", 64'(c_req), 64'(k <= exp_req));
      check("busy", 64'(c_busy), 64'(k < exp_done));
      if (c_req) begin
        check("be", 64'(c_be), s ? 64'h0F : 64'hFF);
        if (stream_ok && nreq < q_addr.size()) begin
          ok = (c_we === q_we[nreq]) && (int'(c_addr) == q_addr[nreq]);
          check("op_we_addr", {57'b0, c_we, c_addr}, {57'b0, q_we[nreq], 6'(q_addr[nreq])});
          if (q_we[nreq]) begin
            exp_wd = q_wv[nreq] ? ones : 64'b0;
            ok = ok && (c_wdata === exp_wd);
            check("op_wdata", c_wdata, exp_wd);
          end
          if (!ok) stream_ok = 1'b0;
        end
        nreq++;
        if (int'(c_addr) > maxaddr) maxaddr = int'(c_addr);
      end else begin
        check("idle_bus", 64'(c_we) | 64'(c_addr) | c_wdata, 64'd0);
      end
      if (c_done) begin
        got_done = 1'b1;
        check("done_cycle", 64'(k), 64'(exp_done));
        check("req_count", 64'(nreq), 64'(exp_req));
        check("pass", 64'(c_pass), 64'(fail_idx < 0));
        check("fail_addr", 64'(c_fa), (fail_idx < 0) ? 64'd0 : 64'(fail_addr));
        break;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("addr_in_range", 64'(maxaddr < n), 64'd1);
    @(negedge clk);
    check("done_pulse_end", 64'(c_done), 64'd0);
    check("idle_busy", 64'(c_busy), 64'd0);
    check("pass_held", 64'(c_pass), 64'(got_done && fail_idx < 0));
  endtask

  initial begin
    int n, w, b;
    bit s;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1;
    check("reset_outputs0", 64'(c_req) | 64'(c_busy) | 64'(c_done) | 64'(c_pass) | 64'(c_fa), 64'd0);
    sel = 1'b1; #1;
    check("reset_outputs1", 64'(c_req) | 64'(c_busy) | 64'(c_done) | 64'(c_pass) | 64'(c_fa), 64'd0);
    rst_n = 1'b1;

    fault_kind = 0;
    run_test(1'b0, -1, -1);                     // fault-free, done at 642
    fault_kind = 1; f_addr = 17; f_mask = 64'd1 << 5;
    run_test(1'b0, -1, -1);                     // stuck-at-1, done at 101, fail 17
    fault_kind = 0;
    run_test(1'b1, -1, -1);                     // 48 words x 32 bits, done at 482
    run_test(1'b0, 300, -1);                    // restart request mid-run ignored
    run_test(1'b0, -1, 200);                    // reset mid-run
    run_test(1'b0, -1, -1);                     // fresh start after reset
    fault_kind = 3; c_agg = 10; c_vic = 11;
    run_test(1'b0, -1, -1);                     // coupling, fail 11

    for (int r = 0; r < 8; r++) begin
      s = 1'($urandom_range(1));
      n = s ? N1 : N0;
      w = s ? W1 : W0;
      fault_kind = $urandom_range(3);
      f_addr = $urandom_range(n - 1);
      b = $urandom_range(w - 1);
      f_mask = 64'd1 << b;
      c_agg = $urandom_range(n - 1);
      c_vic = (c_agg + 1 + $urandom_range(n - 2)) % n;
      run_test(s, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
